// File: rtl/rca_result_accumulator_pkg.sv
// Shared definitions for the adder-result accumulator.
//   state_e : batch FSM states (IDLE, ACCUM, DONE)
//   SUM_W   : width of one adder result {cout, sum[7:0]}
//   CNT_W   : width of the per-batch sample counter
package rca_result_accumulator_pkg;

  localparam int unsigned SUM_W = 9;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rca_result_accumulator.sv
// Batched summation stage behind the 8-bit ripple-carry adder.
// Accepts SAMPLES adder results {in_cout, in_sum} over a valid/ready
// handshake, accumulates them modulo 2^ACC_W and presents the batch total
// with a sticky wrap flag on an output valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake (in_ready low only in DONE)
//   in_sum, in_cout      : adder result, sampled only on accept
//   out_valid/out_ready  : output handshake (out_valid high in DONE)
//   out_total            : registered accumulator
//   out_ovf              : accumulator wrapped during this batch
//   busy                 : batch in progress (state ACCUM)
module rca_result_accumulator
  import rca_result_accumulator_pkg::*;
#(
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);

  if (SAMPLES < 1 || SAMPLES > 255 || ACC_W < 9) begin : g_param_check
    $error("rca_result_accumulator: SAMPLES must be 1..255 and ACC_W >= 9");
  end

  localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(SAMPLES);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [SUM_W-1:0]   v;
  logic [ACC_W:0]     sum_full;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  assign v        = {in_cout, in_sum};
  // One extra bit on the add so the wrap carry is visible for the sticky flag.
  assign sum_full = {1'b0, acc_q} + (ACC_W+1)'(v);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(v);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (SAMPLES == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = sum_full[ACC_W-1:0];
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | sum_full[ACC_W];
          state_d = (cnt_inc == SAMPLES_C) ? DONE : ACCUM;
        end
      end
      DONE: begin
        // acc/cnt/ovf are left as-is; the next IDLE accept reloads them.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign out_total = acc_q;
  assign out_ovf   = ovf_q;

endmodule
